// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands load in parallel, one bit per cycle
// LSB-first through a pair of half-adders, result presented in parallel.

// Half-adder cell; the serial slice chains two of these plus an OR.
module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; sum/cout hold the last result
// ADD    | one bit slice per edge, WIDTH edges total, busy=1
// DONE   | single-cycle done pulse, returns to IDLE unconditionally
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] shr_q, shr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    count_q, count_d;

    logic s1, c1, s_bit, c2, c_bit;

    // Full-adder slice built from two half-adders; the carry flop closes the loop.
    ha u_ha0 (.a(sha_q[0]), .b(shb_q[0]), .s(s1),    .c(c1));
    ha u_ha1 (.a(s1),       .b(carry_q),  .s(s_bit), .c(c2));
    assign c_bit = c1 | c2;

    // Next-state and datapath updates; everything holds unless a state acts on it.
    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        shr_d   = shr_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sha_d   = a;
                    shb_d   = b;
                    shr_d   = '0;
                    carry_d = 1'b0;
                    count_d = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                sha_d   = sha_q >> 1;
                shb_d   = shb_q >> 1;
                shr_d   = {s_bit, shr_q[WIDTH-1:1]};
                carry_d = c_bit;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    // Final slice: publish the fully shifted result with this edge's bit.
                    sum_d   = {s_bit, shr_q[WIDTH-1:1]};
                    cout_d  = c_bit;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            shr_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            shr_q   <= shr_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            count_q <= count_d;
        end
    end

    assign busy = (state_q == S_ADD);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule
